// File: rtl/cva6v_trace_pkg.sv
// Shared types and constants for the CVA6V retirement trace path.
package cva6v_trace_pkg;

  localparam int unsigned TRACE_XLEN = 64;
  localparam int unsigned TRACE_ILEN = 32;
  localparam int unsigned ORDER_W    = 64;
  localparam int unsigned DROP_CNT_W = 16;

  typedef struct packed {
    logic [ORDER_W-1:0]    order;
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_ILEN-1:0] insn;
    logic                  trap;
    logic [1:0]            mode;
    logic                  rd_we;
    logic [4:0]            rd_addr;
    logic [TRACE_XLEN-1:0] rd_wdata;
  } trace_entry_t;

  // Saturating add for the dropped-event counter.
  function automatic logic [DROP_CNT_W-1:0] drop_sat_add(
    input logic [DROP_CNT_W-1:0] a,
    input logic [DROP_CNT_W-1:0] b
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/cva6v_trace_fifo.sv
// Multi-push (contiguous, up to NRET per cycle), single-pop trace entry storage.
module cva6v_trace_fifo
  import cva6v_trace_pkg::*;
#(
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1,
  localparam int unsigned KW = $clog2(NRET + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [KW-1:0]           push_cnt_i,
  input  trace_entry_t [NRET-1:0] push_data_i,
  input  logic                    pop_i,
  output trace_entry_t            head_o,
  output logic [CW-1:0]           count_o
);

  trace_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_cnt_i);
      rd_ptr_q <= rd_ptr_q + AW'(pop_i);
      count_q  <= count_q + CW'(push_cnt_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !clear_i) begin
      for (int i = 0; i < NRET; i++) begin
        if (KW'(i) < push_cnt_i) begin
          mem[wr_ptr_q + AW'(i)] <= push_data_i[i];
        end
      end
    end
  end

  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cva6v_retire_trace_collector.sv
// Collects per-lane retirement events, tags them with order numbers and
// streams them one per cycle to the coverage sampler; overflow drops, never stalls.
module cva6v_retire_trace_collector
  import cva6v_trace_pkg::*;
#(
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = TRACE_XLEN,
  parameter int unsigned ILEN  = TRACE_ILEN
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [NRET-1:0]         ret_valid_i,
  input  logic [NRET*XLEN-1:0]    ret_pc_i,
  input  logic [NRET*ILEN-1:0]    ret_insn_i,
  input  logic [NRET-1:0]         ret_trap_i,
  input  logic [NRET*2-1:0]       ret_mode_i,
  input  logic [NRET-1:0]         ret_rd_we_i,
  input  logic [NRET*5-1:0]       ret_rd_addr_i,
  input  logic [NRET*XLEN-1:0]    ret_rd_wdata_i,
  output logic                    trc_valid_o,
  input  logic                    trc_ready_i,
  output logic [ORDER_W-1:0]      trc_order_o,
  output logic [XLEN-1:0]         trc_pc_o,
  output logic [ILEN-1:0]         trc_insn_o,
  output logic                    trc_trap_o,
  output logic [1:0]              trc_mode_o,
  output logic                    trc_rd_we_o,
  output logic [4:0]              trc_rd_addr_o,
  output logic [XLEN-1:0]         trc_rd_wdata_o,
  output logic [$clog2(DEPTH):0]  fill_o,
  output logic                    overflow_o,
  output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned KW = $clog2(NRET + 1);

  trace_entry_t [NRET-1:0] lane_data;
  trace_entry_t            head;
  logic [KW-1:0]           k;
  logic [KW-1:0]           push_cnt;
  logic [CW-1:0]           count;
  logic [CW-1:0]           free;
  logic                    accept;
  logic                    drop;
  logic                    pop;

  logic [ORDER_W-1:0]      order_q;
  logic                    overflow_q;
  logic [DROP_CNT_W-1:0]   drop_cnt_q;

  // Compact valid lanes into consecutive slots, lane 0 first, and number them.
  always_comb begin
    lane_data = '0;
    k         = '0;
    for (int i = 0; i < NRET; i++) begin
      if (ret_valid_i[i]) begin
        for (int j = 0; j < NRET; j++) begin
          if (k == KW'(j)) begin
            lane_data[j].order    = order_q + ORDER_W'(j);
            lane_data[j].pc       = ret_pc_i[i*XLEN +: XLEN];
            lane_data[j].insn     = ret_insn_i[i*ILEN +: ILEN];
            lane_data[j].trap     = ret_trap_i[i];
            lane_data[j].mode     = ret_mode_i[i*2 +: 2];
            lane_data[j].rd_we    = ret_rd_we_i[i];
            lane_data[j].rd_addr  = ret_rd_addr_i[i*5 +: 5];
            lane_data[j].rd_wdata = ret_rd_wdata_i[i*XLEN +: XLEN];
          end
        end
        k = k + KW'(1);
      end
    end
  end

  // Admission is all-or-nothing against the occupancy before this cycle's pop.
  assign free        = CW'(DEPTH) - count;
  assign accept      = !clear_i && (CW'(k) <= free);
  assign drop        = !clear_i && (CW'(k) > free);
  assign push_cnt    = accept ? k : '0;
  assign trc_valid_o = (count != '0);
  assign pop         = trc_valid_o && trc_ready_i && !clear_i;

  cva6v_trace_fifo #(
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .push_cnt_i  (push_cnt),
    .push_data_i (lane_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  // Order keeps advancing on drops so the sampler sees the gap; clear keeps it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      order_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clear_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      order_q <= order_q + ORDER_W'(k);
      if (drop) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= drop_sat_add(drop_cnt_q, DROP_CNT_W'(k));
      end
    end
  end

  assign trc_order_o    = trc_valid_o ? head.order    : '0;
  assign trc_pc_o       = trc_valid_o ? head.pc       : '0;
  assign trc_insn_o     = trc_valid_o ? head.insn     : '0;
  assign trc_trap_o     = trc_valid_o ? head.trap     : 1'b0;
  assign trc_mode_o     = trc_valid_o ? head.mode     : '0;
  assign trc_rd_we_o    = trc_valid_o ? head.rd_we    : 1'b0;
  assign trc_rd_addr_o  = trc_valid_o ? head.rd_addr  : '0;
  assign trc_rd_wdata_o = trc_valid_o ? head.rd_wdata : '0;
  assign fill_o         = count;
  assign overflow_o     = overflow_q;
  assign drop_cnt_o     = drop_cnt_q;

endmodule
